// File: rtl/change_dispense_ctrl_if.sv
// Signal bundle between the vending core / coin ejectors and the change
// dispense sequencer. The master side drives requests and ejector feedback.
interface change_dispense_ctrl_if;
    logic       start;
    logic [7:0] change_in;
    logic       empty_25;
    logic       empty_10;
    logic       empty_5;
    logic       eject_ack;
    logic [2:0] eject_req;
    logic       busy;
    logic       done;
    logic       fault;
    logic [7:0] shortfall;
    logic [5:0] n_quarters;
    logic [5:0] n_dimes;
    logic [5:0] n_nickels;

    modport master (
        output start, change_in, empty_25, empty_10, empty_5, eject_ack,
        input  eject_req, busy, done, fault, shortfall,
               n_quarters, n_dimes, n_nickels
    );

    modport slave (
        input  start, change_in, empty_25, empty_10, empty_5, eject_ack,
        output eject_req, busy, done, fault, shortfall,
               n_quarters, n_dimes, n_nickels
    );
endinterface

// File: rtl/change_dispense_ctrl.sv
// Greedy change dispenser: breaks a cent amount into quarter/dime/nickel
// ejections, one ejector at a time over a req/ack handshake.
module change_dispense_ctrl #(
    parameter int GAP_CYCLES  = 4,
    parameter int ACK_TIMEOUT = 1000
) (
    input  logic                   clk,
    input  logic                   reset,
    change_dispense_ctrl_if.slave  bus
);

    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

    localparam logic [2:0] REQ_25 = 3'b100;
    localparam logic [2:0] REQ_10 = 3'b010;
    localparam logic [2:0] REQ_5  = 3'b001;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PICK,
        S_EJECT,
        S_GAP,
        S_DONE
    } state_t;

    state_t          r_state;
    logic [7:0]      r_remaining;
    logic [GW-1:0]   r_gap_cnt;
    logic [TW-1:0]   r_tmo_cnt;
    logic [2:0]      r_eject_req;
    logic            r_fault;
    logic [7:0]      r_shortfall;
    logic [5:0]      r_n_quarters;
    logic [5:0]      r_n_dimes;
    logic [5:0]      r_n_nickels;

    state_t          w_state_nxt;
    logic [7:0]      w_remaining_nxt;
    logic [GW-1:0]   w_gap_cnt_nxt;
    logic [TW-1:0]   w_tmo_cnt_nxt;
    logic [2:0]      w_eject_req_nxt;
    logic            w_fault_nxt;
    logic [7:0]      w_shortfall_nxt;
    logic [5:0]      w_n_quarters_nxt;
    logic [5:0]      w_n_dimes_nxt;
    logic [5:0]      w_n_nickels_nxt;

    logic [2:0]      w_pick_req;
    logic [7:0]      w_coin_val;

    // Greedy choice; empty flags only matter where this is consumed (PICK).
    always_comb begin
        w_pick_req = 3'b000;
        if (r_remaining >= 8'd25 && !bus.empty_25) begin
            w_pick_req = REQ_25;
        end else if (r_remaining >= 8'd10 && !bus.empty_10) begin
            w_pick_req = REQ_10;
        end else if (r_remaining >= 8'd5 && !bus.empty_5) begin
            w_pick_req = REQ_5;
        end
    end

    always_comb begin
        case (r_eject_req)
            REQ_25:  w_coin_val = 8'd25;
            REQ_10:  w_coin_val = 8'd10;
            REQ_5:   w_coin_val = 8'd5;
            default: w_coin_val = 8'd0;
        endcase
    end

    always_comb begin
        // NOTE: every next-value defaults to its current register first, so no
        // path through the case below can leave a signal unassigned and infer a latch.
        w_state_nxt      = r_state;
        w_remaining_nxt  = r_remaining;
        w_gap_cnt_nxt    = r_gap_cnt;
        w_tmo_cnt_nxt    = r_tmo_cnt;
        w_eject_req_nxt  = r_eject_req;
        w_fault_nxt      = r_fault;
        w_shortfall_nxt  = r_shortfall;
        w_n_quarters_nxt = r_n_quarters;
        w_n_dimes_nxt    = r_n_dimes;
        w_n_nickels_nxt  = r_n_nickels;

        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_remaining_nxt  = bus.change_in;
                    w_fault_nxt      = 1'b0;
                    w_shortfall_nxt  = 8'd0;
                    w_n_quarters_nxt = 6'd0;
                    w_n_dimes_nxt    = 6'd0;
                    w_n_nickels_nxt  = 6'd0;
                    w_state_nxt      = S_PICK;
                end
            end

            S_PICK: begin
                if (w_pick_req != 3'b000) begin
                    w_eject_req_nxt = w_pick_req;
                    w_tmo_cnt_nxt   = '0;
                    w_state_nxt     = S_EJECT;
                end else begin
                    w_shortfall_nxt = r_remaining;
                    w_state_nxt     = S_DONE;
                end
            end

            S_EJECT: begin
                if (bus.eject_ack) begin
                    w_eject_req_nxt = 3'b000;
                    w_remaining_nxt = r_remaining - w_coin_val;
                    if (r_eject_req == REQ_25) w_n_quarters_nxt = r_n_quarters + 6'd1;
                    if (r_eject_req == REQ_10) w_n_dimes_nxt    = r_n_dimes + 6'd1;
                    if (r_eject_req == REQ_5)  w_n_nickels_nxt  = r_n_nickels + 6'd1;
                    if (GAP_CYCLES == 0) begin
                        w_state_nxt = S_PICK;
                    end else begin
                        w_gap_cnt_nxt = '0;
                        w_state_nxt   = S_GAP;
                    end
                end else if (r_tmo_cnt == TW'(ACK_TIMEOUT - 1)) begin
                    // Unacknowledged coin is not deducted from what we owe.
                    w_eject_req_nxt = 3'b000;
                    w_fault_nxt     = 1'b1;
                    w_shortfall_nxt = r_remaining;
                    w_state_nxt     = S_DONE;
                end else begin
                    w_tmo_cnt_nxt = r_tmo_cnt + 1'b1;
                end
            end

            S_GAP: begin
                if (r_gap_cnt == GW'(GAP_CYCLES - 1)) begin
                    w_state_nxt = S_PICK;
                end else begin
                    w_gap_cnt_nxt = r_gap_cnt + 1'b1;
                end
            end

            S_DONE: begin
                w_state_nxt = S_IDLE;
            end

            default: begin
                w_state_nxt     = S_IDLE;
                w_eject_req_nxt = 3'b000;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_remaining  <= 8'd0;
            r_gap_cnt    <= '0;
            r_tmo_cnt    <= '0;
            r_eject_req  <= 3'b000;
            r_fault      <= 1'b0;
            r_shortfall  <= 8'd0;
            r_n_quarters <= 6'd0;
            r_n_dimes    <= 6'd0;
            r_n_nickels  <= 6'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_remaining  <= w_remaining_nxt;
            r_gap_cnt    <= w_gap_cnt_nxt;
            r_tmo_cnt    <= w_tmo_cnt_nxt;
            r_eject_req  <= w_eject_req_nxt;
            r_fault      <= w_fault_nxt;
            r_shortfall  <= w_shortfall_nxt;
            r_n_quarters <= w_n_quarters_nxt;
            r_n_dimes    <= w_n_dimes_nxt;
            r_n_nickels  <= w_n_nickels_nxt;
        end
    end

    assign bus.eject_req  = r_eject_req;
    assign bus.busy       = (r_state != S_IDLE);
    assign bus.done       = (r_state == S_DONE);
    assign bus.fault      = r_fault;
    assign bus.shortfall  = r_shortfall;
    assign bus.n_quarters = r_n_quarters;
    assign bus.n_dimes    = r_n_dimes;
    assign bus.n_nickels  = r_n_nickels;

endmodule
